// File: rtl/edge_pkg.sv
// Shared constants for the multi-channel edge detector: FSM state encodings
// and the per-channel edge-mode selector values.
package edge_pkg;

  // Edge-tracking FSM states
  localparam logic [1:0] ZERO = 2'b00;
  localparam logic [1:0] RISE = 2'b01;
  localparam logic [1:0] ONE  = 2'b10;
  localparam logic [1:0] FALL = 2'b11;

  // Per-channel mode field: bit 0 enables rising edges, bit 1 falling edges
  localparam logic [1:0] MODE_OFF  = 2'b00;
  localparam logic [1:0] MODE_RISE = 2'b01;
  localparam logic [1:0] MODE_FALL = 2'b10;
  localparam logic [1:0] MODE_BOTH = 2'b11;

endpackage

// File: rtl/edge_channel.sv
// One edge-detector channel: input synchroniser, tick-paced debouncer,
// four-state edge FSM, Moore/Mealy tick decode and a sticky pending flag.
module edge_channel
  import edge_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DB_COUNT    = 4,
  parameter int DB_WIDTH    = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       sample_en,
  input  logic       level,
  input  logic [1:0] mode,
  input  logic       clear,
  output logic       level_db,
  output logic       moore_tick,
  output logic       mealy_tick,
  output logic       pending
);

  localparam logic [DB_WIDTH-1:0] DB_LIMIT = DB_WIDTH'(DB_COUNT);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [DB_WIDTH-1:0]    cnt_q, cnt_d, cnt_inc;
  logic                   level_db_q, level_db_d;
  logic [1:0]             state_q, state_d;
  logic                   pending_q, pending_d;
  logic                   s;
  logic                   rise_en, fall_en;

  assign s       = sync_q[SYNC_STAGES-1];
  assign cnt_inc = cnt_q + DB_WIDTH'(1);

  // Shift the raw input through the synchroniser chain every clock
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], level};
  end

  // Debounce: a new level must persist DB_COUNT sample strobes; 0 means follow s directly
  always_comb begin
    level_db_d = level_db_q;
    cnt_d      = cnt_q;
    if (DB_COUNT == 0) begin
      level_db_d = s;
      cnt_d      = '0;
    end else if (s == level_db_q) begin
      cnt_d = '0;
    end else if (sample_en) begin
      if (cnt_inc == DB_LIMIT) begin
        level_db_d = s;
        cnt_d      = '0;
      end else begin
        cnt_d = cnt_inc;
      end
    end
  end

  // Edge FSM follows level_db regardless of mode; RISE/FALL last one cycle each
  always_comb begin
    state_d = state_q;
    case (state_q)
      ZERO:    state_d = level_db_q ? RISE : ZERO;
      RISE:    state_d = level_db_q ? ONE  : FALL;
      ONE:     state_d = level_db_q ? ONE  : FALL;
      FALL:    state_d = level_db_q ? RISE : ZERO;
      default: state_d = ZERO;
    endcase
  end

  assign rise_en = (mode == MODE_RISE) || (mode == MODE_BOTH);
  assign fall_en = (mode == MODE_FALL) || (mode == MODE_BOTH);

  // Moore tick comes from state alone; Mealy tick sees the new level one cycle earlier
  assign moore_tick = ((state_q == RISE) && rise_en) || ((state_q == FALL) && fall_en);
  assign mealy_tick = (rise_en && level_db_q && ((state_q == ZERO) || (state_q == FALL))) ||
                      (fall_en && !level_db_q && ((state_q == ONE) || (state_q == RISE)));

  // Sticky pending: a new event wins over a simultaneous clear so it is never lost
  always_comb begin
    pending_d = mealy_tick | (pending_q & ~clear);
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q     <= '0;
      cnt_q      <= '0;
      level_db_q <= 1'b0;
      state_q    <= ZERO;
      pending_q  <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      cnt_q      <= cnt_d;
      level_db_q <= level_db_d;
      state_q    <= state_d;
      pending_q  <= pending_d;
    end
  end

  assign level_db = level_db_q;
  assign pending  = pending_q;

endmodule

// File: rtl/multi_edge_detector.sv
// N-channel edge detector top: slices the buses and instantiates one
// independent edge_channel per input.
module multi_edge_detector #(
  parameter int N           = 4,
  parameter int SYNC_STAGES = 2,
  parameter int DB_COUNT    = 4,
  parameter int DB_WIDTH    = 3
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           sample_en,
  input  logic [N-1:0]   level,
  input  logic [2*N-1:0] mode,
  input  logic [N-1:0]   clear,
  output logic [N-1:0]   level_db,
  output logic [N-1:0]   moore_tick,
  output logic [N-1:0]   mealy_tick,
  output logic [N-1:0]   pending
);

  for (genvar gi = 0; gi < N; gi++) begin : g_ch
    edge_channel #(
      .SYNC_STAGES (SYNC_STAGES),
      .DB_COUNT    (DB_COUNT),
      .DB_WIDTH    (DB_WIDTH)
    ) u_ch (
      .clk        (clk),
      .reset_n    (reset_n),
      .sample_en  (sample_en),
      .level      (level[gi]),
      .mode       (mode[2*gi+1:2*gi]),
      .clear      (clear[gi]),
      .level_db   (level_db[gi]),
      .moore_tick (moore_tick[gi]),
      .mealy_tick (mealy_tick[gi]),
      .pending    (pending[gi])
    );
  end

endmodule

// File: tb/tb_multi_edge_detector.sv
// Directed bench for multi_edge_detector: one debounced instance (DB_COUNT=4)
// and one bypass instance (DB_COUNT=0) sharing the same stimulus.
module tb_multi_edge_detector;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       sample_en;
  logic [3:0] level;
  logic [7:0] mode;
  logic [3:0] clear;

  logic [3:0] level_db_db, moore_db, mealy_db, pending_db;
  logic [3:0] level_db_bp, moore_bp, mealy_bp, pending_bp;

  int passed = 0;
  int total  = 0;

  int rise_cnt  [4];
  int fall_cnt  [4];
  int moore_cnt [4];
  int db_ticks;
  int snap_rise [4];
  int snap_fall [4];
  int snap_moore[4];
  int snap_db;

  always #5 clk = ~clk;

  multi_edge_detector #(.N(4), .SYNC_STAGES(2), .DB_COUNT(4), .DB_WIDTH(3)) dut_db (
    .clk(clk), .reset_n(reset_n), .sample_en(sample_en), .level(level), .mode(mode),
    .clear(clear), .level_db(level_db_db), .moore_tick(moore_db), .mealy_tick(mealy_db),
    .pending(pending_db)
  );

  multi_edge_detector #(.N(4), .SYNC_STAGES(2), .DB_COUNT(0), .DB_WIDTH(3)) dut_bp (
    .clk(clk), .reset_n(reset_n), .sample_en(sample_en), .level(level), .mode(mode),
    .clear(clear), .level_db(level_db_bp), .moore_tick(moore_bp), .mealy_tick(mealy_bp),
    .pending(pending_bp)
  );

  // Tick counters sampled mid-cycle; mealy ticks classified by the new level
  initial begin
    for (int i = 0; i < 4; i++) begin
      rise_cnt[i] = 0; fall_cnt[i] = 0; moore_cnt[i] = 0;
    end
    db_ticks = 0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        if (mealy_bp[i] === 1'b1) begin
          if (level_db_bp[i] === 1'b1) rise_cnt[i]++;
          else fall_cnt[i]++;
        end
        if (moore_bp[i] === 1'b1) moore_cnt[i]++;
      end
      if ((mealy_db | moore_db) !== 4'h0) db_ticks++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse();
    sample_en = 1'b1;
    tick();
    sample_en = 1'b0;
  endtask

  task automatic settle();
    repeat (4) tick();
    repeat (4) pulse();
    repeat (2) tick();
  endtask

  task automatic clear_all();
    clear = 4'hF;
    tick();
    clear = 4'h0;
  endtask

  task automatic snapshot();
    for (int i = 0; i < 4; i++) begin
      snap_rise[i]  = rise_cnt[i];
      snap_fall[i]  = fall_cnt[i];
      snap_moore[i] = moore_cnt[i];
    end
    snap_db = db_ticks;
  endtask

  initial begin
    // 1: reset with inputs high, then release
    reset_n = 1'b0; sample_en = 1'b0; level = 4'hF; mode = 8'hFF; clear = 4'h0;
    repeat (3) tick();
    check("rst_bp_outputs", {16'h0, level_db_bp, moore_bp, mealy_bp, pending_bp}, 32'h0);
    check("rst_db_outputs", {16'h0, level_db_db, moore_db, mealy_db, pending_db}, 32'h0);
    reset_n = 1'b1;
    tick(); tick();
    check("rel_bp_ldb_t2", {28'h0, level_db_bp}, 32'h0);
    tick();
    check("rel_bp_ldb_t3", {28'h0, level_db_bp}, 32'hF);
    check("rel_bp_mealy_t3", {28'h0, mealy_bp}, 32'hF);
    check("rel_bp_moore_t3", {28'h0, moore_bp}, 32'h0);
    tick();
    check("rel_bp_moore_t4", {28'h0, moore_bp}, 32'hF);
    check("rel_bp_mealy_t4", {28'h0, mealy_bp}, 32'h0);
    check("rel_bp_pending", {28'h0, pending_bp}, 32'hF);
    repeat (3) pulse();
    check("rel_db_ldb_3smp", {28'h0, level_db_db}, 32'h0);
    pulse();
    check("rel_db_ldb_4smp", {28'h0, level_db_db}, 32'hF);
    check("rel_db_mealy", {28'h0, mealy_db}, 32'hF);
    tick();
    check("rel_db_moore", {28'h0, moore_db}, 32'hF);
    check("rel_db_pending", {28'h0, pending_db}, 32'hF);
    level = 4'h0;
    settle();
    clear_all();
    check("clr_bp_pending", {28'h0, pending_bp}, 32'h0);
    check("clr_db_pending", {28'h0, pending_db}, 32'h0);

    // 2: debounce glitch of 3 samples must not propagate; 4 samples must
    level = 4'b0001;
    repeat (3) tick();
    snapshot();
    repeat (3) pulse();
    check("db_glitch_3smp", {31'h0, level_db_db[0]}, 32'h0);
    level = 4'b0000;
    repeat (4) tick();
    check("db_glitch_after", {31'h0, level_db_db[0]}, 32'h0);
    check("db_glitch_noticks", db_ticks - snap_db, 32'h0);
    level = 4'b0001;
    repeat (3) tick();
    repeat (3) pulse();
    check("db_hold_3smp", {31'h0, level_db_db[0]}, 32'h0);
    pulse();
    check("db_hold_4smp", {31'h0, level_db_db[0]}, 32'h1);
    check("db_hold_mealy", {31'h0, mealy_db[0]}, 32'h1);
    level = 4'h0;
    settle();
    clear_all();

    // 3: per-channel modes off/rise/fall/both over a full 0->1->0 cycle
    mode = 8'b11_10_01_00;
    snapshot();
    level = 4'hF;
    settle();
    level = 4'h0;
    settle();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("mode_rise_ch%0d", i), rise_cnt[i] - snap_rise[i], (i == 1 || i == 3) ? 1 : 0);
      check($sformatf("mode_fall_ch%0d", i), fall_cnt[i] - snap_fall[i], (i == 2 || i == 3) ? 1 : 0);
      check($sformatf("mode_moore_ch%0d", i), moore_cnt[i] - snap_moore[i], (i == 3) ? 2 : ((i == 0) ? 0 : 1));
    end
    check("mode_pending", {28'h0, pending_bp}, 32'hE);

    // 4: bypass latency on channel 1
    mode = 8'hFF;
    clear_all();
    tick();
    level = 4'b0010;
    tick(); tick();
    check("lat_ldb_t2", {28'h0, level_db_bp}, 32'h0);
    tick();
    check("lat_ldb_t3", {28'h0, level_db_bp}, 32'h2);
    check("lat_mealy_t3", {28'h0, mealy_bp}, 32'h2);
    check("lat_moore_t3", {28'h0, moore_bp}, 32'h0);
    tick();
    check("lat_mealy_t4", {28'h0, mealy_bp}, 32'h0);
    check("lat_moore_t4", {28'h0, moore_bp}, 32'h2);
    tick();
    check("lat_moore_t5", {28'h0, moore_bp}, 32'h0);

    // 5: set beats simultaneous clear on pending[2]
    clear_all();
    check("pend_cleared", {28'h0, pending_bp}, 32'h0);
    level = 4'b0110;
    repeat (3) tick();
    check("pend_mealy2", {28'h0, mealy_bp}, 32'h4);
    clear = 4'b0100;
    tick();
    check("pend_set_wins", {31'h0, pending_bp[2]}, 32'h1);
    tick();
    check("pend_clear_next", {31'h0, pending_bp[2]}, 32'h0);
    clear = 4'h0;

    // 6: async reset while ch3 is in RISE and the debouncer is mid-count
    level = 4'b1110;
    tick(); tick();
    sample_en = 1'b1;
    tick();
    check("arst_pre_mealy", {28'h0, mealy_bp}, 32'h8);
    tick();
    sample_en = 1'b0;
    check("arst_pre_moore", {28'h0, moore_bp}, 32'h8);
    #2 reset_n = 1'b0;
    #1;
    check("arst_bp_immediate", {16'h0, level_db_bp, moore_bp, mealy_bp, pending_bp}, 32'h0);
    check("arst_db_immediate", {16'h0, level_db_db, moore_db, mealy_db, pending_db}, 32'h0);
    level = 4'h0;
    repeat (2) tick();
    check("arst_bp_held", {16'h0, level_db_bp, moore_bp, mealy_bp, pending_bp}, 32'h0);
    reset_n = 1'b1;
    snapshot();
    settle();
    check("arst_rel_ldb", {24'h0, level_db_db, level_db_bp}, 32'h0);
    check("arst_rel_noticks_db", db_ticks - snap_db, 32'h0);
    check("arst_rel_noticks_bp",
          (rise_cnt[0] + rise_cnt[1] + rise_cnt[2] + rise_cnt[3] + fall_cnt[0] + fall_cnt[1] +
           fall_cnt[2] + fall_cnt[3] + moore_cnt[0] + moore_cnt[1] + moore_cnt[2] + moore_cnt[3]) -
          (snap_rise[0] + snap_rise[1] + snap_rise[2] + snap_rise[3] + snap_fall[0] + snap_fall[1] +
           snap_fall[2] + snap_fall[3] + snap_moore[0] + snap_moore[1] + snap_moore[2] + snap_moore[3]),
          32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
